// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared FSM state codes, register select codes and width helper for the interrupt controller
package irq_pkg;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  // cfg_sel register codes
  localparam logic [1:0] CFG_MASK     = 2'd0;
  localparam logic [1:0] CFG_MODE     = 2'd1;
  localparam logic [1:0] CFG_PEND_CLR = 2'd2;
  localparam logic [1:0] CFG_PEND_SET = 2'd3;

  // Channel index width; a single-channel build still needs a 1-bit id
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
// Ports:
//   req  in  NUM_IRQ  candidate request bits
//   any  out 1        at least one request bit is set
//   idx  out ID_W     index of the lowest set request bit (0 when none)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 24,
  parameter int ID_W    = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // Scan from the top down so the lowest set index is the last write
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised interrupt controller with edge/level channels and vectored request
// Ports:
//   clk         in  1        clock, rising edge
//   rst         in  1        asynchronous active-low reset
//   irq         in  NUM_IRQ  asynchronous interrupt request lines
//   cfg_we      in  1        configuration write strobe
//   cfg_sel     in  2        register select: mask, mode, pending-clear, pending-set
//   cfg_wdata   in  NUM_IRQ  configuration write data
//   cfg_rdata   out NUM_IRQ  mask / mode / pending / pending for cfg_sel 0..3
//   irq_req     out 1        interrupt request to the processor
//   irq_ack     in  1        processor acknowledge pulse
//   irq_id      out ID_W     channel being requested or serviced
//   irq_vector  out ADDR_W   VECTOR_BASE + irq_id * VECTOR_STRIDE
//   eoi         in  1        end-of-interrupt pulse
//   busy        out 1        high while servicing
module irq_controller
  import irq_pkg::*;
#(
  parameter int                NUM_IRQ       = 24,
  parameter int                ADDR_W        = 24,
  parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(24'o00000100),
  parameter int unsigned       VECTOR_STRIDE = 4,
  parameter int                ID_W          = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  output logic [NUM_IRQ-1:0] cfg_rdata,
  output logic               irq_req,
  input  logic               irq_ack,
  output logic [ID_W-1:0]    irq_id,
  output logic [ADDR_W-1:0]  irq_vector,
  input  logic               eoi,
  output logic               busy
);

  logic [NUM_IRQ-1:0] sync1, sync2, sync_prev;
  logic [NUM_IRQ-1:0] mask, mode, pending;
  logic [NUM_IRQ-1:0] rise, clr_v, set_v, pend_next, elig;
  logic [1:0]         state;
  logic [ID_W-1:0]    id;
  logic               win_any;
  logic [ID_W-1:0]    win_idx;

  // Two-flop synchronizer plus a history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= irq;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

  // Edge channels: set sources (edge, pending-set) override clear sources
  // (pending-clear, acknowledge). Level channels simply track sync2.
  always_comb begin
    clr_v = '0;
    set_v = rise;
    if (cfg_we && cfg_sel == CFG_PEND_CLR) clr_v = cfg_wdata;
    if (cfg_we && cfg_sel == CFG_PEND_SET) set_v = rise | cfg_wdata;
    if (state == ST_REQUEST && irq_ack) clr_v[id] = 1'b1;
    pend_next = (mode & sync2) | (~mode & ((pending & ~clr_v) | set_v));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      pending <= pend_next;
      if (cfg_we && cfg_sel == CFG_MASK) mask <= cfg_wdata;
      if (cfg_we && cfg_sel == CFG_MODE) mode <= cfg_wdata;
    end
  end

  assign elig = pending & mask;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req (elig),
    .any (win_any),
    .idx (win_idx)
  );

  // The winner is latched on leaving IDLE and held until the next arbitration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      id    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            id    <= win_idx;
            state <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          // Acknowledge wins over a same-cycle loss of eligibility
          if (irq_ack)       state <= ST_SERVICE;
          else if (!elig[id]) state <= ST_IDLE;
        end
        ST_SERVICE: begin
          if (eoi) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (cfg_sel)
      CFG_MASK: cfg_rdata = mask;
      CFG_MODE: cfg_rdata = mode;
      default:  cfg_rdata = pending;
    endcase
  end

  assign irq_req    = (state == ST_REQUEST);
  assign busy       = (state == ST_SERVICE);
  assign irq_id     = id;
  assign irq_vector = VECTOR_BASE + ADDR_W'(id) * ADDR_W'(VECTOR_STRIDE);

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller against a channel-level reference model
module tb_irq_controller;

  localparam int N = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  irq, cfg_wdata, cfg_rdata;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic          irq_ack, eoi, irq_req, busy;
  logic [4:0]    irq_id;
  logic [23:0]   irq_vector;

  logic [63:0]   irq2, cfg_wdata2, cfg_rdata2;
  logic          cfg_we2;
  logic [1:0]    cfg_sel2;
  logic          irq_ack2, eoi2, irq_req2, busy2;
  logic [5:0]    irq_id2;
  logic [23:0]   irq_vector2;

  irq_controller dut (
    .clk(clk), .rst(rst_n), .irq(irq), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq_req(irq_req), .irq_ack(irq_ack),
    .irq_id(irq_id), .irq_vector(irq_vector), .eoi(eoi), .busy(busy)
  );

  irq_controller #(.NUM_IRQ(64), .VECTOR_STRIDE(8)) dut2 (
    .clk(clk), .rst(rst_n), .irq(irq2), .cfg_we(cfg_we2), .cfg_sel(cfg_sel2),
    .cfg_wdata(cfg_wdata2), .cfg_rdata(cfg_rdata2), .irq_req(irq_req2), .irq_ack(irq_ack2),
    .irq_id(irq_id2), .irq_vector(irq_vector2), .eoi(eoi2), .busy(busy2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: irq samples seen at the last three edges, per-channel
  // registers, and the transaction phase (0 idle, 1 requesting, 2 servicing).
  logic [N-1:0] m_d1, m_d2, m_d3, m_mask, m_mode, m_pend;
  int m_phase, m_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_d3 = '0;
    m_mask = '0; m_mode = '0; m_pend = '0;
    m_phase = 0; m_id = 0;
  endtask

  // One clock: predict from the spec rules, advance, then compare everything
  task automatic tick();
    logic [N-1:0] elig, clr, set, npend, nmask, nmode;
    int nphase, nid;
    elig   = m_pend & m_mask;
    set    = m_d2 & ~m_d3;
    clr    = '0;
    nphase = m_phase;
    nid    = m_id;
    nmask  = m_mask;
    nmode  = m_mode;
    if (cfg_we && cfg_sel == 2'd2) clr = cfg_wdata;
    if (cfg_we && cfg_sel == 2'd3) set = set | cfg_wdata;
    if (cfg_we && cfg_sel == 2'd0) nmask = cfg_wdata;
    if (cfg_we && cfg_sel == 2'd1) nmode = cfg_wdata;
    case (m_phase)
      0: if (elig != '0) begin
        int k = 0;
        while (!elig[k]) k++;
        nid = k;
        nphase = 1;
      end
      1: if (irq_ack) begin
        nphase = 2;
        clr[m_id] = 1'b1;
      end else if (!elig[m_id]) nphase = 0;
      default: if (eoi) nphase = 0;
    endcase
    for (int i = 0; i < N; i++)
      npend[i] = m_mode[i] ? m_d2[i] : ((m_pend[i] && !clr[i]) || set[i]);
    @(posedge clk);
    m_d3 = m_d2; m_d2 = m_d1; m_d1 = irq;
    m_pend = npend; m_mask = nmask; m_mode = nmode;
    m_phase = nphase; m_id = nid;
    #1;
    chk("irq_req", 64'(irq_req), 64'(m_phase == 1));
    chk("busy", 64'(busy), 64'(m_phase == 2));
    chk("irq_id", 64'(irq_id), 64'(m_id));
    chk("irq_vector", 64'(irq_vector), 64'(64 + m_id * 4));
    chk("cfg_rdata", 64'(cfg_rdata),
        64'((cfg_sel == 2'd0) ? m_mask : (cfg_sel == 2'd1) ? m_mode : m_pend));
    cfg_we = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [N-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    tick();
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!irq_req && n < budget) begin tick(); n++; end
    chk(tag, 64'(irq_req), 64'(1));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; irq = '0; cfg_we = 1'b0; cfg_sel = 2'd2; cfg_wdata = '0;
    irq_ack = 1'b0; eoi = 1'b0;
    irq2 = '0; cfg_we2 = 1'b0; cfg_sel2 = 2'd0; cfg_wdata2 = '0; irq_ack2 = 1'b0; eoi2 = 1'b0;
    model_reset();
    #12;
    chk("rst_req", 64'(irq_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_id", 64'(irq_id), 64'(0));
    chk("rst_vector", 64'(irq_vector), 64'(24'o00000100));
    chk("rst_pending", 64'(cfg_rdata), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Edge channel 5: pending at edge 3, request at edge 4
    cfg_write(2'd0, '1);
    cfg_sel = 2'd2;
    irq[5] = 1'b1;
    tick(); tick(); tick();
    chk("e37_no_req_edge3", 64'(irq_req), 64'(0));
    chk("e37_pend_edge3", 64'(cfg_rdata[5]), 64'(1));
    irq[5] = 1'b0;
    tick();
    chk("e37_req_edge4", 64'(irq_req), 64'(1));
    chk("e37_id", 64'(irq_id), 64'(5));
    chk("e37_vector", 64'(irq_vector), 64'(24'o00000124));
    irq_ack = 1'b1; tick();
    chk("e37_busy", 64'(busy), 64'(1));
    chk("e37_pend_cleared", 64'(cfg_rdata[5]), 64'(0));
    eoi = 1'b1; tick();
    chk("e37_idle", 64'(busy), 64'(0));

    // Priority: 2 beats 9, then 9 two cycles after eoi
    irq[9] = 1'b1; irq[2] = 1'b1;
    wait_req("e38_req", 8);
    irq[9] = 1'b0; irq[2] = 1'b0;
    chk("e38_id2", 64'(irq_id), 64'(2));
    irq_ack = 1'b1; tick();
    eoi = 1'b1; tick();
    chk("e38_gap", 64'(irq_req), 64'(0));
    tick();
    chk("e38_req9", 64'(irq_req), 64'(1));
    chk("e38_id9", 64'(irq_id), 64'(9));
    irq_ack = 1'b1; tick();
    eoi = 1'b1; tick();

    // Masking: pending recorded while masked, request once unmasked
    cfg_write(2'd0, 24'hFFFFF7);
    irq[3] = 1'b1;
    tick(); tick(); tick();
    irq[3] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("e39_masked_req", 64'(irq_req), 64'(0));
    cfg_sel = 2'd2; #1;
    chk("e39_pend3", 64'(cfg_rdata[3]), 64'(1));
    cfg_write(2'd0, '1);
    tick();
    chk("e39_req", 64'(irq_req), 64'(1));
    chk("e39_id", 64'(irq_id), 64'(3));
    irq_ack = 1'b1; tick();
    eoi = 1'b1; tick();

    // Level channel 7: withdraw before ack, then ack on the drop cycle
    cfg_write(2'd1, 24'h000080);
    irq[7] = 1'b1;
    wait_req("e40_req", 8);
    chk("e40_id", 64'(irq_id), 64'(7));
    irq[7] = 1'b0;
    n = 0;
    while (irq_req && n < 8) begin tick(); n++; end
    chk("e40_withdrawn", 64'(irq_req), 64'(0));
    chk("e40_not_busy", 64'(busy), 64'(0));
    irq[7] = 1'b1;
    wait_req("e40_req2", 8);
    irq[7] = 1'b0;
    cfg_sel = 2'd2;
    n = 0;
    while (cfg_rdata[7] && n < 8) begin tick(); n++; end
    chk("e40_still_req", 64'(irq_req), 64'(1));
    irq_ack = 1'b1; tick();
    chk("e40_service", 64'(busy), 64'(1));
    eoi = 1'b1; tick();
    cfg_write(2'd1, '0);

    // Reset in the middle of SERVICE with other channels pending
    irq[1] = 1'b1;
    wait_req("e41_req", 8);
    irq[1] = 1'b0;
    irq_ack = 1'b1; tick();
    cfg_write(2'd3, 24'h000F00);
    chk("e41_busy", 64'(busy), 64'(1));
    cfg_sel = 2'd2;
    #3 rst_n = 1'b0;
    #1;
    chk("e41_req", 64'(irq_req), 64'(0));
    chk("e41_busy0", 64'(busy), 64'(0));
    chk("e41_pending", 64'(cfg_rdata), 64'(0));
    chk("e41_id", 64'(irq_id), 64'(0));
    chk("e41_vector", 64'(irq_vector), 64'(24'o00000100));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the model
    cfg_write(2'd0, '1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) irq[$urandom_range(N-1)] ^= 1'b1;
      cfg_sel = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) begin
        cfg_we = 1'b1;
        cfg_wdata = N'($urandom);
        if (cfg_sel == 2'd0) cfg_wdata = cfg_wdata | N'($urandom);
      end
      irq_ack = ($urandom_range(2) == 0);
      eoi = ($urandom_range(3) == 0);
      tick();
    end

    // 64-channel, stride-8 build: channel 63 vector
    cfg_we2 = 1'b1; cfg_sel2 = 2'd0; cfg_wdata2 = '1;
    @(posedge clk); #1;
    cfg_we2 = 1'b0;
    irq2[63] = 1'b1;
    n = 0;
    while (!irq_req2 && n < 10) begin @(posedge clk); #1; n++; end
    chk("e42_req", 64'(irq_req2), 64'(1));
    chk("e42_id", 64'(irq_id2), 64'(63));
    chk("e42_vector", 64'(irq_vector2), 64'(64 + 504));
    chk("e42_busy", 64'(busy2), 64'(0));
    chk("e42_mask", cfg_rdata2, '1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_IRQ, default 24, SHALL set the number of interrupt channels (1..64).
REQ-002 Parameter ADDR_W, default 24, SHALL set the vector address width.
REQ-003 Parameter VECTOR_BASE, default 24'o00000100, SHALL set the vector address of channel 0.
REQ-004 Parameter VECTOR_STRIDE, default 4, SHALL set the address spacing between consecutive channel vectors.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 irq  input  NUM_IRQ  SHALL carry asynchronous interrupt request lines.
REQ-008 cfg_we  input  1  SHALL be the configuration write strobe, one cycle per write.
REQ-009 cfg_sel  input  2  SHALL select the register: 0 mask-enable, 1 mode (0 edge, 1 level), 2 pending-clear (write-1-to-clear), 3 pending-set (write-1-to-set).
REQ-010 cfg_wdata  input  NUM_IRQ  SHALL be the configuration write data.
REQ-011 cfg_rdata  output  NUM_IRQ  SHALL combinationally return mask, mode, pending, pending for cfg_sel 0..3.
REQ-012 irq_req  output  1  SHALL request interrupt service from the processor.
REQ-013 irq_ack  input  1  SHALL be the one-cycle processor acknowledge.
REQ-014 irq_id  output  $clog2(NUM_IRQ)  SHALL give the channel being requested or serviced.
REQ-015 irq_vector  output  ADDR_W  SHALL give VECTOR_BASE + irq_id * VECTOR_STRIDE, truncated to ADDR_W bits.
REQ-016 eoi  input  1  SHALL be the one-cycle end-of-interrupt pulse.
REQ-017 busy  output  1  SHALL be high while in SERVICE.

Function
REQ-018 Each irq bit SHALL pass a two-flop synchronizer; a third flop SHALL hold the previous synchronized value.
REQ-019 Edge mode: a synchronized 0->1 transition SHALL set pending on the next edge; a synchronized level edge arriving before edge 1 sets pending at edge 3 and raises irq_req at edge 4.
REQ-020 Level mode: pending SHALL equal the synchronized level, except that REQ-009 clear/set writes have no effect on it.
REQ-021 Pending SHALL be recorded regardless of mask; only arbitration is masked.
REQ-022 Same-cycle set and clear of one edge-mode pending bit: set SHALL win.
REQ-023 Arbitration SHALL be fixed priority, lowest index highest, over pending & mask.
REQ-024 FSM states SHALL be IDLE, REQUEST, SERVICE; reset state IDLE.
REQ-025 IDLE: if any eligible bit exists, latch the winner into irq_id and go to REQUEST, with irq_req high from the following cycle.
REQ-026 REQUEST: irq_req SHALL stay high and irq_id stable until irq_ack; winner SHALL NOT be re-arbitrated, even if a higher priority bit arrives.
REQ-027 REQUEST: if the latched channel becomes non-eligible (masked, cleared, level dropped) without irq_ack that cycle, go to IDLE with irq_req low next cycle.
REQ-028 REQUEST with irq_ack (including same-cycle loss of eligibility): clear pending of irq_id if edge mode, drop irq_req, and go to SERVICE.
REQ-029 SERVICE: irq_id and irq_vector SHALL hold; no new request SHALL be raised; on eoi go to IDLE.
REQ-030 irq_ack outside REQUEST and eoi outside SERVICE SHALL be ignored.
REQ-031 Latency from eoi to the next irq_req, with pending eligible, SHALL be 2 cycles (IDLE, then REQUEST).

Reset
REQ-032 Reset SHALL asynchronously clear all synchronizer flops, pending, mask (all disabled), and mode (all edge), and set the FSM to IDLE.
REQ-033 Outputs during and after reset SHALL be irq_req 0, irq_id 0, irq_vector VECTOR_BASE, and busy 0.
REQ-034 Reset asserted mid-REQUEST or mid-SERVICE SHALL abandon the transaction; no state survives reset.

Structure
REQ-035 FSM state encoding and cfg_sel register codes SHALL live in shared package irq_pkg.
REQ-036 The priority encoder SHALL be a sub-module, irq_prio_enc, parametrised by NUM_IRQ, with outputs any and idx.

Verification
REQ-037 Edge interrupt: mask=all ones, pulse irq[5] for 3 cycles -> irq_req at edge 4, irq_id=5, irq_vector=24'o00000124; after ack, pending[5]=0.
REQ-038 Priority: irq[9] and irq[2] rise together -> irq_id=2; ack, eoi -> irq_id=9 with irq_req 2 cycles after eoi.
REQ-039 Masking: mask bit 3 cleared, pulse irq[3] -> no irq_req and cfg_rdata(sel 2) bit3=1; set mask bit 3 -> irq_req, irq_id=3.
REQ-040 Level withdraw: mode[7]=1, irq[7] high then low before ack -> irq_req returns low and the FSM returns to IDLE; ack in the same cycle as the drop -> SERVICE.
REQ-041 Reset mid-SERVICE: assert rst low asynchronously -> irq_req=0, busy=0, pending=0 immediately.
REQ-042 Parameters NUM_IRQ=64, VECTOR_STRIDE=8: irq[63] -> irq_vector=VECTOR_BASE+504.
